// File: rtl/apb5_completer_mem_if.sv
// APB5 bus bundle between a requester and the apb5_completer_mem completer.
// The master modport is the requester side and the slave modport is the completer side.
// The parameters must match those of the completer that is attached to the bus.
interface apb5_completer_mem_if #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int USER_REQ_WIDTH  = 4,
  parameter int USER_DATA_WIDTH = 4,
  parameter int USER_RESP_WIDTH = 4
);
  logic                         PSEL;
  logic                         PENABLE;
  logic [ADDR_WIDTH-1:0]        PADDR;
  logic                         PWRITE;
  logic [DATA_WIDTH-1:0]        PWDATA;
  logic [DATA_WIDTH/8-1:0]      PSTRB;
  logic [2:0]                   PPROT;
  logic [USER_REQ_WIDTH-1:0]    PAUSER;
  logic [USER_DATA_WIDTH-1:0]   PWUSER;
  logic                         PREADY;
  logic [DATA_WIDTH-1:0]        PRDATA;
  logic                         PSLVERR;
  logic [USER_DATA_WIDTH-1:0]   PRUSER;
  logic [USER_RESP_WIDTH-1:0]   PBUSER;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PAUSER, PWUSER,
    input  PREADY, PRDATA, PSLVERR, PRUSER, PBUSER
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PAUSER, PWUSER,
    output PREADY, PRDATA, PSLVERR, PRUSER, PBUSER
  );
endinterface

// File: rtl/apb5_completer_mem.sv
// APB5 completer backed by a flop-based word memory with per-word user bits.
// Every access takes WAIT_CYCLES PREADY-low cycles and then a single response cycle.
// Optional macro APB5_COMPLETER_PROT_EN adds PPROT-based access checks; when it is
// undefined, PPROT is ignored and no PPROT flop exists.
module apb5_completer_mem #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH       = 48,
  parameter int WAIT_CYCLES     = 1,
  parameter int USER_REQ_WIDTH  = 4,
  parameter int USER_DATA_WIDTH = 4,
  parameter int USER_RESP_WIDTH = 4
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb5_completer_mem_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                      state_q;
  logic [3:0]                  waitCnt_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        write_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [STRB_WIDTH-1:0]       strb_q;
  logic [USER_REQ_WIDTH-1:0]   auser_q;
  logic [USER_DATA_WIDTH-1:0]  wuser_q;
`ifdef APB5_COMPLETER_PROT_EN
  logic [2:0]                  prot_q;
`endif

  logic                        pready_q;
  logic [DATA_WIDTH-1:0]       prdata_q;
  logic                        pslverr_q;
  logic [USER_DATA_WIDTH-1:0]  pruser_q;
  logic [USER_RESP_WIDTH-1:0]  pbuser_q;

  logic [DATA_WIDTH-1:0]       mem_q  [MEM_DEPTH];
  logic [USER_DATA_WIDTH-1:0]  user_q [MEM_DEPTH];

  logic                        inIdle;
  logic                        setup;
  logic                        goResp_d;
  logic [ADDR_WIDTH-1:0]       reqAddr_d;
  logic                        reqWrite_d;
  logic [DATA_WIDTH-1:0]       reqWdata_d;
  logic [STRB_WIDTH-1:0]       reqStrb_d;
  logic [USER_REQ_WIDTH-1:0]   reqAuser_d;
  logic [USER_DATA_WIDTH-1:0]  reqWuser_d;
  logic [31:0]                 reqIndex_d;
  logic [IDX_W-1:0]            wordIdx_d;
  logic                        reqErr_d;

`ifndef APB5_COMPLETER_PROT_EN
  logic unusedProt;
  assign unusedProt = ^bus.PPROT;
`endif

  // The request that enters RESP comes straight off the bus when there are no wait
  // states, otherwise from the values captured in the setup phase.
  always_comb begin
    inIdle     = (state_q == IDLE);
    setup      = bus.PSEL && !bus.PENABLE;
    goResp_d   = (inIdle && setup && (WAIT_CYCLES == 0)) ||
                 ((state_q == WAIT) && bus.PSEL && (waitCnt_q == 4'd1));
    reqAddr_d  = inIdle ? bus.PADDR  : addr_q;
    reqWrite_d = inIdle ? bus.PWRITE : write_q;
    reqWdata_d = inIdle ? bus.PWDATA : wdata_q;
    reqStrb_d  = inIdle ? bus.PSTRB  : strb_q;
    reqAuser_d = inIdle ? bus.PAUSER : auser_q;
    reqWuser_d = inIdle ? bus.PWUSER : wuser_q;
    reqIndex_d = 32'(reqAddr_d >> OFF_BITS);
    wordIdx_d  = reqIndex_d[IDX_W-1:0];
    reqErr_d   = (reqIndex_d >= 32'(MEM_DEPTH)) ||
                 ((reqAddr_d & OFF_MASK) != '0) ||
                 (!reqWrite_d && (reqStrb_d != '0));
`ifdef APB5_COMPLETER_PROT_EN
    begin
      logic [2:0] reqProt;
      reqProt = inIdle ? bus.PPROT : prot_q;
      if (reqProt[1] && (reqIndex_d >= 32'(MEM_DEPTH / 2))) begin
        reqErr_d = 1'b1;
      end
      if (reqWrite_d && !reqProt[0] && (reqIndex_d == 32'd0)) begin
        reqErr_d = 1'b1;
      end
    end
`endif
  end

  // Transfer FSM: captures the request, counts wait states, and on entry to RESP
  // commits the write or registers the read response for exactly one cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      auser_q   <= '0;
      wuser_q   <= '0;
`ifdef APB5_COMPLETER_PROT_EN
      prot_q    <= '0;
`endif
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      pruser_q  <= '0;
      pbuser_q  <= '0;
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem_q[w]  <= '0;
        user_q[w] <= '0;
      end
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      pruser_q  <= '0;
      pbuser_q  <= '0;

      case (state_q)
        IDLE: begin
          if (setup) begin
            addr_q    <= bus.PADDR;
            write_q   <= bus.PWRITE;
            wdata_q   <= bus.PWDATA;
            strb_q    <= bus.PSTRB;
            auser_q   <= bus.PAUSER;
            wuser_q   <= bus.PWUSER;
`ifdef APB5_COMPLETER_PROT_EN
            prot_q    <= bus.PPROT;
`endif
            waitCnt_q <= 4'(WAIT_CYCLES);
            state_q   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!bus.PSEL) begin
            waitCnt_q <= '0;
            state_q   <= IDLE;
          end else if (waitCnt_q == 4'd1) begin
            waitCnt_q <= '0;
            state_q   <= RESP;
          end else begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (goResp_d) begin
        pready_q  <= 1'b1;
        pslverr_q <= reqErr_d;
        pbuser_q  <= USER_RESP_WIDTH'(reqAuser_d);
        if (!reqErr_d) begin
          if (reqWrite_d) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
              if (reqStrb_d[i]) begin
                mem_q[wordIdx_d][8*i +: 8] <= reqWdata_d[8*i +: 8];
              end
            end
            user_q[wordIdx_d] <= reqWuser_d;
          end else begin
            prdata_q <= mem_q[wordIdx_d];
            pruser_q <= user_q[wordIdx_d];
          end
        end
      end
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PRDATA  = prdata_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRUSER  = pruser_q;
  assign bus.PBUSER  = pbuser_q;

endmodule

// File: tb/tb_apb5_completer_mem.sv
// Scoreboard bench for apb5_completer_mem: instance A has one wait state, instance B
// has none. The driver pushes the expected response of every transfer into a queue
// and a monitor per instance pops it whenever that instance raises PREADY.
module tb_apb5_completer_mem;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  ruser;
    logic        err;
    logic [3:0]  buser;
    int          cyc;
    int          tag;
  } exp_t;

  logic PCLK;
  logic PRESET;

  logic        tSelA;
  logic        tSelB;
  logic        tEnable;
  logic [7:0]  tAddr;
  logic        tWrite;
  logic [31:0] tWdata;
  logic [3:0]  tStrb;
  logic [2:0]  tProt;
  logic [3:0]  tAuser;
  logic [3:0]  tWuser;

  int   vecs;
  int   miss;
  int   cyc;
  exp_t qA[$];
  exp_t qB[$];

  logic [31:0] b2bData [10];

  apb5_completer_mem_if busA ();
  apb5_completer_mem_if busB ();

  assign busA.PSEL    = tSelA;
  assign busA.PENABLE = tEnable;
  assign busA.PADDR   = tAddr;
  assign busA.PWRITE  = tWrite;
  assign busA.PWDATA  = tWdata;
  assign busA.PSTRB   = tStrb;
  assign busA.PPROT   = tProt;
  assign busA.PAUSER  = tAuser;
  assign busA.PWUSER  = tWuser;

  assign busB.PSEL    = tSelB;
  assign busB.PENABLE = tEnable;
  assign busB.PADDR   = tAddr;
  assign busB.PWRITE  = tWrite;
  assign busB.PWDATA  = tWdata;
  assign busB.PSTRB   = tStrb;
  assign busB.PPROT   = tProt;
  assign busB.PAUSER  = tAuser;
  assign busB.PWUSER  = tWuser;

  apb5_completer_mem #(.WAIT_CYCLES(1)) dutA (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (busA)
  );

  apb5_completer_mem #(.WAIT_CYCLES(0)) dutB (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (busB)
  );

  // Free-running clock and cycle counter used for latency checks.
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  initial cyc = 0;
  always @(posedge PCLK) cyc++;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string bus, input exp_t e, input logic [31:0] data,
                             input logic [3:0] ruser, input logic err, input logic [3:0] buser);
    vecs++;
    if (data !== e.data || ruser !== e.ruser || err !== e.err || buser !== e.buser) begin
      miss++;
      $display("[TB] FAIL resp%s tag%0d: got data=%h ruser=%h err=%b buser=%h, want data=%h ruser=%h err=%b buser=%h",
               bus, e.tag, data, ruser, err, buser, e.data, e.ruser, e.err, e.buser);
    end
    vecs++;
    if (cyc != e.cyc) begin
      miss++;
      $display("[TB] FAIL latency%s tag%0d: PREADY in cycle %0d, want %0d", bus, e.tag, cyc, e.cyc);
    end
  endtask

  task automatic checkIdle(input string bus, input logic [31:0] data, input logic [3:0] ruser,
                           input logic err, input logic [3:0] buser);
    vecs++;
    if (data !== '0 || ruser !== '0 || err !== 1'b0 || buser !== '0) begin
      miss++;
      $display("[TB] FAIL idle%s: got data=%h ruser=%h err=%b buser=%h, want all zero",
               bus, data, ruser, err, buser);
    end
  endtask

  // Monitor for instance A: responses are compared against the head of its queue.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (busA.PREADY) begin
        if (qA.size() == 0) begin
          vecs++;
          miss++;
          $display("[TB] FAIL unexpectedA: PREADY=1 in cycle %0d, want no response", cyc);
        end else begin
          checkOutput("A", qA.pop_front(), busA.PRDATA, busA.PRUSER, busA.PSLVERR, busA.PBUSER);
        end
      end else begin
        checkIdle("A", busA.PRDATA, busA.PRUSER, busA.PSLVERR, busA.PBUSER);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (busB.PREADY) begin
        if (qB.size() == 0) begin
          vecs++;
          miss++;
          $display("[TB] FAIL unexpectedB: PREADY=1 in cycle %0d, want no response", cyc);
        end else begin
          checkOutput("B", qB.pop_front(), busB.PRDATA, busB.PRUSER, busB.PSLVERR, busB.PBUSER);
        end
      end else begin
        checkIdle("B", busB.PRDATA, busB.PRUSER, busB.PSLVERR, busB.PBUSER);
      end
    end
  end

  // One complete APB transfer; called #1 after a rising edge, returns #1 after the
  // edge that completes the transfer so a back-to-back setup can follow directly.
  task automatic applyStimulus(input bit onB, input logic wr, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [2:0] prot, input logic [3:0] auser,
                               input logic [3:0] wuser, input logic [31:0] expData,
                               input logic [3:0] expRuser, input logic expErr, input int tag);
    exp_t e;
    bit   done;
    int   wc;
    wc      = onB ? 0 : 1;
    tSelA   = !onB;
    tSelB   = onB;
    tEnable = 1'b0;
    tWrite  = wr;
    tAddr   = addr;
    tWdata  = wdata;
    tStrb   = strb;
    tProt   = prot;
    tAuser  = auser;
    tWuser  = wuser;
    e.data  = expData;
    e.ruser = expRuser;
    e.err   = expErr;
    e.buser = auser;
    e.cyc   = cyc + 1 + wc;
    e.tag   = tag;
    if (onB) qB.push_back(e);
    else     qA.push_back(e);
    @(posedge PCLK);
    #1;
    tEnable = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge PCLK);
      done = onB ? busB.PREADY : busA.PREADY;
    end
    if (!done) begin
      vecs++;
      miss++;
      $display("[TB] FAIL timeout tag%0d: PREADY=0 after 20 cycles, want 1", tag);
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic busIdle(input int n);
    tSelA   = 1'b0;
    tSelB   = 1'b0;
    tEnable = 1'b0;
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wrA(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] strb,
                     input logic [3:0] wuser, input logic expErr, input int tag);
    applyStimulus(1'b0, 1'b1, addr, d, strb, 3'b001, 4'h3, wuser, 32'h0, 4'h0, expErr, tag);
  endtask

  task automatic rdA(input logic [7:0] addr, input logic [3:0] strb, input logic [31:0] expD,
                     input logic [3:0] expU, input logic expErr, input int tag);
    applyStimulus(1'b0, 1'b0, addr, 32'h0, strb, 3'b001, 4'hC, 4'h0, expD, expU, expErr, tag);
  endtask

  initial begin
    vecs    = 0;
    miss    = 0;
    PRESET  = 1'b1;
    tSelA   = 1'b0;
    tSelB   = 1'b0;
    tEnable = 1'b0;
    tAddr   = '0;
    tWrite  = 1'b0;
    tWdata  = '0;
    tStrb   = '0;
    tProt   = 3'b001;
    tAuser  = '0;
    tWuser  = '0;
    b2bData[0] = 32'h01234567; b2bData[1] = 32'h89ABCDEF;
    b2bData[2] = 32'hFFFFFFFF; b2bData[3] = 32'h00000001;
    b2bData[4] = 32'h80000000; b2bData[5] = 32'h5A5A5A5A;
    b2bData[6] = 32'hA5A5A5A5; b2bData[7] = 32'h13579BDF;
    b2bData[8] = 32'h2468ACE0; b2bData[9] = 32'hCAFEBABE;

    repeat (3) @(posedge PCLK);
    #1;
    vecs++;
    if ({busA.PREADY, busA.PRDATA, busA.PSLVERR, busA.PRUSER, busA.PBUSER} !== '0) begin
      miss++;
      $display("[TB] FAIL resetA: outputs=%h, want 0",
               {busA.PREADY, busA.PRDATA, busA.PSLVERR, busA.PRUSER, busA.PBUSER});
    end
    PRESET = 1'b0;
    busIdle(2);

    // Full write and read back, with PRUSER returning the stored PWUSER.
    wrA(8'h04, 32'hDEADBEEF, 4'hF, 4'h5, 1'b0, 1);
    rdA(8'h04, 4'h0, 32'hDEADBEEF, 4'h5, 1'b0, 2);
    // Byte-lane merge, then a zero-strobe no-op write.
    wrA(8'h08, 32'hDEADBEEF, 4'hF, 4'h1, 1'b0, 3);
    wrA(8'h08, 32'h11223344, 4'h5, 4'h2, 1'b0, 4);
    rdA(8'h08, 4'h0, 32'hDE22BE44, 4'h2, 1'b0, 5);
    wrA(8'h08, 32'hFFFFFFFF, 4'h0, 4'h2, 1'b0, 6);
    rdA(8'h08, 4'h0, 32'hDE22BE44, 4'h2, 1'b0, 7);
    busIdle(1);
    // Error cases: out of range, unaligned, read with strobes.
    rdA(8'hC0, 4'h0, 32'h0, 4'h0, 1'b1, 8);
    rdA(8'h05, 4'h0, 32'h0, 4'h0, 1'b1, 9);
    rdA(8'h04, 4'h1, 32'h0, 4'h0, 1'b1, 10);
    wrA(8'hC0, 32'h55555555, 4'hF, 4'h6, 1'b1, 11);
    wrA(8'h05, 32'h66666666, 4'hF, 4'h6, 1'b1, 12);
    rdA(8'h04, 4'h0, 32'hDEADBEEF, 4'h5, 1'b0, 13);
    // Last implemented word.
    wrA(8'hBC, 32'h0BADF00D, 4'hF, 4'h9, 1'b0, 14);
    rdA(8'hBC, 4'h0, 32'h0BADF00D, 4'h9, 1'b0, 15);
    busIdle(1);

    // Reset in the wait state of a write aborts it.
    tSelA   = 1'b1;
    tEnable = 1'b0;
    tWrite  = 1'b1;
    tAddr   = 8'h10;
    tWdata  = 32'hCAFEF00D;
    tStrb   = 4'hF;
    tWuser  = 4'hE;
    @(posedge PCLK);
    #1;
    tEnable = 1'b1;
    #2;
    PRESET = 1'b1;
    #1;
    vecs++;
    if ({busA.PREADY, busA.PRDATA, busA.PSLVERR, busA.PRUSER, busA.PBUSER} !== '0) begin
      miss++;
      $display("[TB] FAIL midReset: outputs=%h, want 0",
               {busA.PREADY, busA.PRDATA, busA.PSLVERR, busA.PRUSER, busA.PBUSER});
    end
    tSelA   = 1'b0;
    tEnable = 1'b0;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    busIdle(1);
    rdA(8'h10, 4'h0, 32'h0, 4'h0, 1'b0, 16);
    rdA(8'h04, 4'h0, 32'h0, 4'h0, 1'b0, 17);
    busIdle(1);

    // PSEL dropped in the wait state aborts the write.
    tSelA   = 1'b1;
    tEnable = 1'b0;
    tWrite  = 1'b1;
    tAddr   = 8'h14;
    tWdata  = 32'h12345678;
    tStrb   = 4'hF;
    @(posedge PCLK);
    #1;
    tSelA = 1'b0;
    @(posedge PCLK);
    #1;
    busIdle(1);
    rdA(8'h14, 4'h0, 32'h0, 4'h0, 1'b0, 18);
    busIdle(1);

`ifdef APB5_COMPLETER_PROT_EN
    applyStimulus(1'b0, 1'b1, 8'h60, 32'h0000FFFF, 4'hF, 3'b010, 4'h1, 4'hA, 32'h0, 4'h0, 1'b1, 19);
    applyStimulus(1'b0, 1'b0, 8'h60, 32'h0, 4'h0, 3'b000, 4'h2, 4'h0, 32'h0, 4'h0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h00000001, 4'hF, 3'b000, 4'h3, 4'hB, 32'h0, 4'h0, 1'b1, 21);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 3'b000, 4'h4, 4'h0, 32'h0, 4'h0, 1'b0, 22);
`else
    applyStimulus(1'b0, 1'b1, 8'h60, 32'h0000FFFF, 4'hF, 3'b010, 4'h1, 4'hA, 32'h0, 4'h0, 1'b0, 19);
    applyStimulus(1'b0, 1'b0, 8'h60, 32'h0, 4'h0, 3'b000, 4'h2, 4'h0, 32'h0000FFFF, 4'hA, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h00000001, 4'hF, 3'b000, 4'h3, 4'hB, 32'h0, 4'h0, 1'b0, 21);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 3'b000, 4'h4, 4'h0, 32'h00000001, 4'hB, 1'b0, 22);
`endif
    busIdle(1);

    // Ten back-to-back writes then ten reads on the zero-wait instance.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(4 * i), b2bData[i], 4'hF, 3'b001, 4'(i), 4'(i),
                    32'h0, 4'h0, 1'b0, 100 + i);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(4 * i), 32'h0, 4'h0, 3'b001, 4'(i + 5), 4'h0,
                    b2bData[i], 4'(i), 1'b0, 200 + i);
    end
    busIdle(4);

    vecs++;
    if (qA.size() != 0 || qB.size() != 0) begin
      miss++;
      $display("[TB] FAIL drain: %0d/%0d responses outstanding, want 0/0", qA.size(), qB.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
